// File: rtl/aes_encipher_round_engine.sv
// aes_encipher_round_engine
//   Iterative AES encipher datapath (initial, main and final rounds of Cipher()).
//   One 128-bit block per 'next' request; SubBytes is done one 32-bit word per
//   cycle through an external S-box shared with key expansion.
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   next       start pulse, sampled only while idle
//   keylen     0 = AES-128, 1 = AES-256, latched when a start is accepted
//   round      current round index, addresses the round key memory
//   round_key  round key for 'round' (combinational from key memory)
//   sboxw      word sent to the shared S-box (0 when not substituting)
//   new_sboxw  S-box result for sboxw, same cycle
//   block      plaintext, must be stable during the INIT cycle
//   new_block  state register {w0,w1,w2,w3}, w0 = bits 127:96
//   ready      1 = idle and new_block valid
module aes_encipher_round_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_INIT = 2'd1;
  localparam logic [1:0] CTRL_SBOX = 2'd2;
  localparam logic [1:0] CTRL_MAIN = 2'd3;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  logic [1:0]   ctrl_reg;
  logic         ready_reg;
  logic [3:0]   round_reg;
  logic [1:0]   sword_ctr_reg;
  logic         keylen_reg;
  logic [127:0] block_reg;

  logic [3:0]   num_rounds;
  logic [127:0] sub_block;
  logic [127:0] shifted;
  logic [127:0] mixed;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gm2(a0) ^ gm3(a1) ^ a2      ^ a3,
            a0      ^ gm2(a1) ^ gm3(a2) ^ a3,
            a0      ^ a1      ^ gm2(a2) ^ gm3(a3),
            gm3(a0) ^ a1      ^ a2      ^ gm2(a3)};
  endfunction

  // Row r of output word c comes from input word (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = s;
    return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
            w1[31:24], w2[23:16], w3[15:8], w0[7:0],
            w2[31:24], w3[23:16], w0[15:8], w1[7:0],
            w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  endfunction

  assign num_rounds = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;
  assign shifted    = shift_rows(block_reg);
  assign mixed      = {mix_word(shifted[127:96]), mix_word(shifted[95:64]),
                       mix_word(shifted[63:32]),  mix_word(shifted[31:0])};

  // The S-box port is only driven while substituting so key expansion can use it.
  always_comb begin
    sboxw     = '0;
    sub_block = block_reg;
    if (ctrl_reg == CTRL_SBOX) begin
      case (sword_ctr_reg)
        2'd0: begin sboxw = block_reg[127:96]; sub_block[127:96] = new_sboxw; end
        2'd1: begin sboxw = block_reg[95:64];  sub_block[95:64]  = new_sboxw; end
        2'd2: begin sboxw = block_reg[63:32];  sub_block[63:32]  = new_sboxw; end
        default: begin sboxw = block_reg[31:0]; sub_block[31:0] = new_sboxw; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg      <= CTRL_IDLE;
      ready_reg     <= 1'b1;
      round_reg     <= '0;
      sword_ctr_reg <= '0;
      keylen_reg    <= 1'b0;
      block_reg     <= '0;
    end else begin
      case (ctrl_reg)
        CTRL_IDLE: begin
          if (next) begin
            ready_reg  <= 1'b0;
            round_reg  <= '0;
            keylen_reg <= keylen;
            ctrl_reg   <= CTRL_INIT;
          end
        end
        CTRL_INIT: begin
          block_reg     <= block ^ round_key;
          round_reg     <= 4'd1;
          sword_ctr_reg <= '0;
          ctrl_reg      <= CTRL_SBOX;
        end
        CTRL_SBOX: begin
          block_reg     <= sub_block;
          sword_ctr_reg <= sword_ctr_reg + 2'd1;
          if (sword_ctr_reg == 2'd3) begin
            ctrl_reg <= CTRL_MAIN;
          end
        end
        CTRL_MAIN: begin
          if (round_reg == num_rounds) begin
            // Final round skips MixColumns; round holds at N afterwards.
            block_reg <= shifted ^ round_key;
            ready_reg <= 1'b1;
            ctrl_reg  <= CTRL_IDLE;
          end else begin
            block_reg     <= mixed ^ round_key;
            round_reg     <= round_reg + 4'd1;
            sword_ctr_reg <= '0;
            ctrl_reg      <= CTRL_SBOX;
          end
        end
        default: ctrl_reg <= CTRL_IDLE;
      endcase
    end
  end

  assign round     = round_reg;
  assign new_block = block_reg;
  assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_encipher_round_engine.sv
// Directed-vector bench for aes_encipher_round_engine. Provides the shared
// S-box and a key memory expanded from the test key.
module tb_aes_encipher_round_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [255:0] K128_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K128_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0] sbox_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  logic [127:0] rk [16];

  assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                      sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};
  assign round_key = rk[round];

  aes_encipher_round_engine dut (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Fills the key memory with the expanded schedule; 128-bit keys sit in bits 255:128.
  task automatic load_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk;
    int nw;
    nk = kl ? 8 : 4;
    nw = kl ? 60 : 44;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (4*r + 3 < nw) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else              rk[r] = '0;
    end
  endtask

  // k counts edges since the one after which next is raised; the start is accepted at k = 1.
  task automatic run_block(input string tag, input logic kl, input logic [127:0] ct,
                           input bit trace, input int poke_at, input int reset_at);
    int k;
    int exp_r;
    int exp_lat;
    exp_lat = kl ? 72 : 52;
    keylen = kl;
    @(posedge clk); #1; next = 1'b1;
    @(posedge clk); #1; next = 1'b0; k = 1;
    check_val({tag, " busy"}, 128'(ready), 128'(0));
    if (trace) check_val({tag, " round0"}, 128'(round), 128'(0));
    while (!ready && k < 200) begin
      if (k == poke_at) begin next = 1'b1; keylen = ~kl; end
      if (k == reset_at) reset = 1'b1;
      @(posedge clk); #1; k++;
      next = 1'b0;
      if (reset) begin
        reset = 1'b0;
        check_val({tag, " rst ready"}, 128'(ready), 128'(1));
        check_val({tag, " rst block"}, new_block, '0);
        check_val({tag, " rst round"}, 128'(round), 128'(0));
        check_val({tag, " rst sboxw"}, 128'(sboxw), 128'(0));
        keylen = kl;
        return;
      end
      if (trace) begin
        exp_r = (k - 2) / 5 + 1;
        if (exp_r > 10) exp_r = 10;
        check_val({tag, " round"}, 128'(round), 128'(exp_r));
        if ((k - 2) % 5 == 4 || ready) check_val({tag, " sboxw idle"}, 128'(sboxw), 128'(0));
      end
    end
    keylen = kl;
    check_val({tag, " latency"}, 128'(k), 128'(exp_lat));
    check_val({tag, " result"}, new_block, ct);
    check_val({tag, " final round"}, 128'(round), 128'(kl ? 14 : 10));
  endtask

  initial begin
    int k;
    reset = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
    load_key('0, 1'b0);
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    check_val("reset ready", 128'(ready), 128'(1));
    check_val("reset round", 128'(round), 128'(0));
    check_val("reset block", new_block, '0);
    check_val("reset sboxw", 128'(sboxw), 128'(0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_val("idle ready", 128'(ready), 128'(1));
    end

    load_key(K128_C1, 1'b0); block = PT_C;
    run_block("c1", 1'b0, CT_C1, 1'b0, 0, 0);
    load_key(K256_C3, 1'b1);
    run_block("c3", 1'b1, CT_C3, 1'b0, 0, 0);
    load_key(K128_B, 1'b0); block = PT_B;
    run_block("fipsb", 1'b0, CT_B, 1'b1, 0, 0);

    load_key(K128_C1, 1'b0); block = PT_C;
    run_block("poke", 1'b0, CT_C1, 1'b0, 20, 0);
    run_block("midrst", 1'b0, CT_C1, 1'b0, 0, 30);

    // Reset and start in the same cycle: the start must not be taken.
    @(posedge clk); #1; reset = 1'b1; next = 1'b1;
    @(posedge clk); #1; reset = 1'b0; next = 1'b0;
    check_val("rst+next ready", 128'(ready), 128'(1));
    @(posedge clk); #1;
    check_val("rst+next idle", 128'(ready), 128'(1));

    run_block("rerun", 1'b0, CT_C1, 1'b0, 0, 0);

    // Back-to-back: next stays high through both blocks.
    keylen = 1'b0;
    @(posedge clk); #1; next = 1'b1;
    @(posedge clk); #1; k = 1;
    check_val("b2b first busy", 128'(ready), 128'(0));
    while (!ready && k < 200) begin @(posedge clk); #1; k++; end
    check_val("b2b first latency", 128'(k), 128'(52));
    check_val("b2b first result", new_block, CT_C1);
    load_key(K128_B, 1'b0); block = PT_B;
    @(posedge clk); #1; k = 1;
    next = 1'b0;
    check_val("b2b restart", 128'(ready), 128'(0));
    while (!ready && k < 200) begin @(posedge clk); #1; k++; end
    check_val("b2b second latency", 128'(k), 128'(52));
    check_val("b2b second result", new_block, CT_B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
